vga_timing_gen: RTL

- 640x480@60 Hz VGA timing generator: divides the system clock into a pixel-rate enable and runs horizontal/vertical counters.
- Produces h_sync, v_sync, DE and pixel_x/pixel_y for the downstream stages: the RGB switch path and test_pattern_gen in the VGA RGB controller top.
- All outputs are registered and mutually aligned.
- Adds a pixel-enable strobe and a frame-start pulse so downstream logic can run frame-synchronous on the system clock.

---
 rtl/vga_timing_gen_if.sv | 21 ++
 rtl/vga_timing_gen.sv | 114 +++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: timing outputs of vga_timing_gen bundled for downstream stages.
// The master modport drives the bundle (the timing generator). The slave modport
// receives it (RGB switch path, test_pattern_gen).
interface vga_timing_gen_if;
    logic       pix_tick;
    logic       h_sync;
    logic       v_sync;
    logic       DE;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_start;
    logic [7:0] frame_cnt;

    modport master (
        output pix_tick, h_sync, v_sync, DE, pixel_x, pixel_y, frame_start, frame_cnt
    );

    modport slave (
        input pix_tick, h_sync, v_sync, DE, pixel_x, pixel_y, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA timing generator with a pixel-rate enable.
// Every output is a register. DE, sync and frame_start are decoded from the next-state
// counter values, so they always match the pixel_x/pixel_y being presented.
// Optional frame counter: define VGA_FRAME_CNT_EN. Without it, frame_cnt is tied to zero.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] H_SS     = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SE     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] V_SS     = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SE     = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [3:0] r_div,         w_div_d;
    logic       r_pix_tick,    w_pix_tick_d;
    logic [9:0] r_h_cnt,       w_h_cnt_d;
    logic [9:0] r_v_cnt,       w_v_cnt_d;
    logic       r_de,          w_de_d;
    logic       r_h_sync,      w_h_sync_d;
    logic       r_v_sync,      w_v_sync_d;
    logic       r_frame_start, w_frame_start_d;

    // Next-state: divider, counters (advance after each tick cycle) and decoded outputs
    always_comb begin
        w_div_d      = (r_div == DIV_LAST) ? 4'd0 : r_div + 4'd1;
        w_pix_tick_d = (w_div_d == DIV_LAST);
        w_h_cnt_d    = r_h_cnt;
        w_v_cnt_d    = r_v_cnt;
        // r_pix_tick rather than r_div so the reset cycle never advances, even at CLK_DIV=1
        if (r_pix_tick) begin
            if (r_h_cnt == H_LAST) begin
                w_h_cnt_d = 10'd0;
                w_v_cnt_d = (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                w_h_cnt_d = r_h_cnt + 10'd1;
            end
        end
        w_de_d          = (w_h_cnt_d < H_VIS) && (w_v_cnt_d < V_VIS);
        w_h_sync_d      = !((w_h_cnt_d >= H_SS) && (w_h_cnt_d < H_SE));
        w_v_sync_d      = !((w_v_cnt_d >= V_SS) && (w_v_cnt_d < V_SE));
        w_frame_start_d = w_pix_tick_d && (w_h_cnt_d == 10'd0) && (w_v_cnt_d == 10'd0);
    end

    // State and output registers; reset presents pixel (0,0) with syncs idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div         <= 4'd0;
            r_pix_tick    <= 1'b0;
            r_h_cnt       <= 10'd0;
            r_v_cnt       <= 10'd0;
            r_de          <= 1'b1;
            r_h_sync      <= 1'b1;
            r_v_sync      <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_d;
            r_pix_tick    <= w_pix_tick_d;
            r_h_cnt       <= w_h_cnt_d;
            r_v_cnt       <= w_v_cnt_d;
            r_de          <= w_de_d;
            r_h_sync      <= w_h_sync_d;
            r_v_sync      <= w_v_sync_d;
            r_frame_start <= w_frame_start_d;
        end
    end

    assign vga.pix_tick    = r_pix_tick;
    assign vga.h_sync      = r_h_sync;
    assign vga.v_sync      = r_v_sync;
    assign vga.DE          = r_de;
    assign vga.pixel_x     = r_h_cnt;
    assign vga.pixel_y     = r_v_cnt;
    assign vga.frame_start = r_frame_start;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;
    logic       w_frame_wrap;

    assign w_frame_wrap = r_pix_tick && (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);

    // Frame counter steps on the edge where (H_TOTAL-1, V_TOTAL-1) wraps to (0, 0)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= 8'd0;
        end else if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign vga.frame_cnt = r_frame_cnt;
`else
    assign vga.frame_cnt = 8'd0;
`endif

endmodule
